// File: rtl/fir_pkg.sv
// Shared definitions for the FIR/ALU sequencer: ALU width, ALU select codes and FSM states.
package fir_pkg;

    localparam int AW = 38;

    localparam logic SEL_MUL = 1'b0;
    localparam logic SEL_ADD = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ADD,
        CAP,
        DONE
    } state_t;

endpackage

// File: rtl/fir_tap_regs.sv
// Sample delay line and coefficient register file.
// x[k] and c[k] are presented combinationally for the tap currently selected by k.
module fir_tap_regs #(
    parameter int NTAPS = 8,
    parameter int DW    = 16,
    parameter int KW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          shift,
    input  logic [DW-1:0] sample,
    input  logic          cfg_we,
    input  logic [KW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic [KW-1:0] k,
    output logic [DW-1:0] x_k,
    output logic [DW-1:0] c_k
);
    import fir_pkg::*;

    logic [DW-1:0] x [NTAPS];
    logic [DW-1:0] c [NTAPS];
    logic          addr_ok;

    // Addresses beyond the last tap are dropped rather than aliased.
    assign addr_ok = ({1'b0, cfg_addr} < (KW+1)'(NTAPS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                x[i] <= '0;
            end
        end else if (shift) begin
            x[0] <= sample;
            for (int i = 1; i < NTAPS; i++) begin
                x[i] <= x[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                c[i] <= '0;
            end
        end else if (cfg_we && addr_ok) begin
            c[cfg_addr] <= cfg_data;
        end
    end

    assign x_k = x[k];
    assign c_k = c[k];

endmodule

// File: rtl/fir_alu_sequencer.sv
// Drives a shared multiply/add ALU through MUL, ADD and CAP for every tap and
// presents the accumulated FIR result on a valid/ready output port.
module fir_alu_sequencer #(
    parameter int NTAPS = 8,
    parameter int DW    = 16,
    parameter int AW    = fir_pkg::AW
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     IN_VALID,
    input  logic [DW-1:0]            IN_DATA,
    output logic                     IN_READY,
    output logic                     OUT_VALID,
    output logic [AW-1:0]            OUT_DATA,
    input  logic                     OUT_READY,
    input  logic                     CFG_WE,
    input  logic [$clog2(NTAPS)-1:0] CFG_ADDR,
    input  logic [DW-1:0]            CFG_DATA,
    output logic                     BUSY,
    output logic [AW-1:0]            ALU_A,
    output logic [AW-1:0]            ALU_B,
    output logic                     ALU_SEL,
    input  logic [AW-1:0]            ALU_ANS
);
    import fir_pkg::*;

    localparam int KW = $clog2(NTAPS);

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k;
    logic [AW-1:0] acc;
    logic [DW-1:0] x_k;
    logic [DW-1:0] c_k;
    logic          idle;
    logic          accept;
    logic          last_tap;

    assign idle     = (state == IDLE);
    assign accept   = IN_VALID && idle;
    assign last_tap = (k == KW'(NTAPS - 1));

    // Coefficient writes are only honoured while idle, so a write coincident
    // with an accept is visible to that very sample.
    fir_tap_regs #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .KW    (KW)
    ) u_tap_regs (
        .clk      (CLK),
        .rst_n    (RESETN),
        .shift    (accept),
        .sample   (IN_DATA),
        .cfg_we   (CFG_WE && idle),
        .cfg_addr (CFG_ADDR),
        .cfg_data (CFG_DATA),
        .k        (k),
        .x_k      (x_k),
        .c_k      (c_k)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ALU_SEL   = SEL_MUL;
        ALU_A     = '0;
        ALU_B     = '0;
        case (state)
            IDLE: begin
                if (IN_VALID) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                ALU_A     = {{(AW-DW){1'b0}}, x_k};
                ALU_B     = {{(AW-DW){1'b0}}, c_k};
                state_nxt = ADD;
            end
            // The product registered by the ALU during MUL feeds straight back in.
            ADD: begin
                ALU_SEL   = SEL_ADD;
                ALU_A     = acc;
                ALU_B     = ALU_ANS;
                state_nxt = CAP;
            end
            CAP: begin
                state_nxt = last_tap ? DONE : MUL;
            end
            DONE: begin
                if (OUT_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            k   <= '0;
            acc <= '0;
        end else if (accept) begin
            k   <= '0;
            acc <= '0;
        end else if (state == CAP) begin
            acc <= ALU_ANS;
            if (!last_tap) begin
                k <= k + 1'b1;
            end
        end
    end

    assign IN_READY  = idle;
    assign BUSY      = !idle;
    assign OUT_VALID = (state == DONE);
    assign OUT_DATA  = OUT_VALID ? acc : '0;

endmodule

// File: doc/fir_alu_sequencer.md
# fir_alu_sequencer

Sequences the shared 38-bit `alu` (SELECT=0 multiply, SELECT=1 add, registered ANS) to compute one FIR output per accepted input sample. Holds the tap delay line and the coefficient register file. For each tap it issues a multiply and then an add through the ALU, and returns y = Σ c[k]·x[k] on a valid/ready output port. It sits between the sample source and the output sink, and owns the only path into the ALU.

## Interface
- `NTAPS`, 8: number of taps (≥2).
- `DW`, 16: sample and coefficient width, unsigned.
- `AW`, 38: ALU/accumulator width.
- `CLK` in 1: single clock, rising edge.
- `RESETN` in 1: reset, asynchronous and active-low.
- `IN_VALID` in 1: sample offered.
- `IN_DATA` in DW: sample value.
- `IN_READY` out 1: high only in IDLE.
- `OUT_VALID` out 1: result held.
- `OUT_DATA` out AW: filter result.
- `OUT_READY` in 1: sink accepts.
- `CFG_WE` in 1: coefficient write strobe.
- `CFG_ADDR` in clog2(NTAPS): tap index.
- `CFG_DATA` in DW: coefficient value.
- `BUSY` out 1: high in any state other than IDLE.
- `ALU_A` out AW: ALU operand A.
- `ALU_B` out AW: ALU operand B.
- `ALU_SEL` out 1: ALU SELECT.
- `ALU_ANS` in AW: ALU ANS, valid one cycle after its operands are presented.

## Operation
- **States:** IDLE, MUL, ADD, CAP, DONE. Tap counter k runs 0..NTAPS-1.
- **IDLE:**
  - An accept is IN_VALID & IN_READY at a rising edge.
  - On accept: x[0]←IN_DATA, x[i]←x[i-1], acc←0, k←0, next state MUL.
  - A CFG_WE with CFG_ADDR<NTAPS writes c[CFG_ADDR]←CFG_DATA.
  - A CFG_WE in IDLE and an accept in the same cycle are both honoured. The new coefficient applies to this sample.
  - CFG_WE in any other state is ignored.
  - CFG_ADDR≥NTAPS is ignored.
- **MUL:** ALU_SEL=0, ALU_A=zext(x[k]), ALU_B=zext(c[k]). Next state ADD.
- **ADD:** ALU_SEL=1, ALU_A=acc, ALU_B=ALU_ANS (the product). Next state CAP.
- **CAP:**
  - acc←ALU_ANS.
  - If k=NTAPS-1, next state DONE. Otherwise k←k+1 and next state MUL.
  - Operands are 0 and ALU_SEL=0.
- **DONE:** OUT_VALID=1, OUT_DATA=acc. When OUT_READY=1, next state IDLE. OUT_DATA is stable while OUT_VALID=1 and OUT_READY=0.
- **Idle outputs:** In IDLE and DONE, ALU_A=ALU_B=0 and ALU_SEL=0.
- **Arithmetic:**
  - Unsigned; operands are zero-extended to AW.
  - acc wraps modulo 2^AW; there is no saturation and no overflow flag.
- **Reset (RESETN=0):**
  - State IDLE, k=0, acc=0, all x[i]=0, all c[i]=0.
  - OUT_VALID=0, OUT_DATA=0, BUSY=0, ALU outputs 0.
  - IN_READY=1 once RESETN is high.
  - Reset mid-operation discards the result in progress and the delay line.

## Timing
- Accept at edge E0. MUL for tap 0 occupies the cycle after E0.
- Each tap takes exactly 3 cycles.
- OUT_VALID rises at edge E0+3·NTAPS.
- The earliest next accept is the edge after the OUT handshake edge.
- Minimum period is 3·NTAPS+2 cycles per sample.
- IN_READY, BUSY, OUT_VALID and the ALU operand outputs are decoded from registered state and k. The only combinational input path is ALU_ANS→ALU_B in ADD.
- ALU latency is fixed at 1 cycle. The ALU's own RESETN is driven by the same reset net.

## Structure
- **Package `fir_pkg`:**
  - AW=38.
  - SEL_MUL=1'b0, SEL_ADD=1'b1.
  - State enum {IDLE, MUL, ADD, CAP, DONE}.
- **Sub-module `fir_tap_regs`:** the delay-line shift register plus the coefficient RF with write port. It exposes x[k] and c[k] muxed by k.
- **Top level:** the FSM, k, acc and output register. It instantiates `fir_tap_regs`. The ALU is not instantiated here; it is connected at the level above.

## Test plan
Real `alu` connected, NTAPS=4, DW=16.
- **Impulse:** coefficients {1,2,3,4}; samples 1,0,0,0,0 → OUT_DATA 1,2,3,4,0. OUT_VALID rises exactly 12 cycles after each accept.
- **Max-value sum:** all coefficients 65535; samples 65535 ×4 → fourth output 17179344900. Separately, with AW forced to 32, check the wrap (mod 2^32) result.
- **Backpressure:** OUT_READY held low 10 cycles after OUT_VALID → OUT_DATA stable, IN_READY=0 and IN_VALID ignored throughout. Sample is accepted only after the handshake.
- **Config while busy:** CFG_WE addr 0 data 9 during MUL of tap 2 → c[0] unchanged. The same write in IDLE, coincident with an accept, applies to that sample.
- **Reset mid-run:** RESETN low during CAP of tap 1 → next-edge-free outputs all 0, IN_READY=1 after release, and the next impulse with reloaded coefficients yields output c[0].
- **Operand trace:** check ALU_SEL/A/B per cycle follow MUL, ADD, CAP for k=0..3, with operands 0 in IDLE, CAP and DONE.
